fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the instruction memory and downstream decode.
- Owns the program counter and drives the word address into the combinational-read instruction memory.
- Captures each returned word together with its PC into a small prefetch queue.
- Presents queue entries to decode over a valid/ready handshake; accepts taken-branch/jump redirects from execute.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 52 +++++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: word width, reset PC, NOP encoding and the queue entry layout.
package fetch_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch_entry_t; head readable in the cycle after a push, flush empties it.
// Latency 1 cycle push-to-head; simultaneous push/pop allowed when full, caller honours full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   storage [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= push_entry;
  end

  assign head  = storage[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, prefetch queue, redirect handling; FETCH_MISALIGN_TRAP_EN halts on misaligned targets.
// First instruction 1 cycle after reset release, redirect target 2 cycles after; fetch stops while the queue is full.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC = fetch_pkg::RESET_PC,
  parameter int                DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] if_instr,
  output logic            if_misaligned
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_tgt;
  logic            halted;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  fetch_entry_t    new_entry;
  fetch_entry_t    head;

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (redirect_valid) begin
      halted <= |redirect_pc[1:0];
    end
  end
  assign redirect_tgt  = redirect_pc;
  assign if_misaligned = halted && rst_n;
`else
  assign halted        = 1'b0;
  assign redirect_tgt  = redirect_pc & ~XLEN'(3);
  assign if_misaligned = 1'b0;
`endif

  // A redirect squashes both handshakes in its own cycle; the queue is flushed at the edge.
  assign if_valid = rst_n && !empty && !redirect_valid && !halted;
  assign pop      = if_valid && if_ready;
  assign push     = (!full || pop) && !redirect_valid && !halted;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_tgt;
    end else if (push) begin
      pc <= pc + XLEN'(4);
    end
  end

  assign imem_addr       = pc;
  assign new_entry.pc    = pc;
  assign new_entry.instr = imem_rdata;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_entry(new_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign if_pc       = head.pc;
  assign if_instr    = head.instr;
  assign if_pc_plus4 = head.pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized stream checked against an expected-PC scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] imem_addr, imem_rdata, redirect_pc, if_pc, if_pc_plus4, if_instr;
  logic         redirect_valid, if_valid, if_ready, if_misaligned;
  logic [W-1:0] mem [256];
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rst_n ? mem[imem_addr[9:2]] : NOP_INSTR;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_instr(if_instr), .if_misaligned(if_misaligned)
  );

  // Memory content rule: word index i holds 0x1000_0000 + i, aliasing every 1 KiB.
  function automatic logic [W-1:0] word_at(input logic [W-1:0] a);
    return 32'h1000_0000 + {24'h0, a[9:2]};
  endfunction

  // Drive inputs for one cycle at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic rv, input logic [W-1:0] rpc, input logic rdy);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) drive(1'b0, '0, 1'b1);
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    n_tests++; if (if_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned got %b exp 0", if_misaligned); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid got %b exp 0", if_valid); end
  endtask

  task automatic test_stream;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, '0, 1'b1);
      n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b exp 1", k, if_valid); end
      n_tests++; if (if_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_pc[%0d] got %h exp %h", k, if_pc, 32'(4 * k)); end
      n_tests++; if (if_instr !== word_at(32'(4 * k))) begin n_fail++; $display("FAIL stream_instr[%0d] got %h exp %h", k, if_instr, word_at(32'(4 * k))); end
      n_tests++; if (if_pc_plus4 !== 32'(4 * k + 4)) begin n_fail++; $display("FAIL stream_plus4[%0d] got %h exp %h", k, if_pc_plus4, 32'(4 * k + 4)); end
    end
  endtask

  task automatic test_stall;
    for (int s = 0; s < 5; s++) begin
      drive(1'b0, '0, 1'b0);
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin n_fail++; $display("FAIL stall_hold[%0d] got v=%b pc=%h exp v=1 pc=8", s, if_valid, if_pc); end
      n_tests++; if (if_instr !== word_at(32'h8)) begin n_fail++; $display("FAIL stall_instr[%0d] got %h exp %h", s, if_instr, word_at(32'h8)); end
      if (s >= 1) begin
        n_tests++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL stall_addr[%0d] got %h exp 10", s, imem_addr); end
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1);
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'(8 + 4 * k)) begin n_fail++; $display("FAIL resume[%0d] got v=%b pc=%h exp v=1 pc=%h", k, if_valid, if_pc, 32'(8 + 4 * k)); end
    end
  endtask

  task automatic test_redirect;
    drive(1'b1, 32'h8, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL prefill got v=%b pc=%h addr=%h exp v=1 pc=8 addr=10", if_valid, if_pc, imem_addr); end
    drive(1'b1, 32'h40, 1'b1);
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_cycle_valid got %b exp 0", if_valid); end
    drive(1'b0, '0, 1'b1);
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gap_valid got %b exp 0", if_valid); end
    drive(1'b0, '0, 1'b1);
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin n_fail++; $display("FAIL redir_target got v=%b pc=%h exp v=1 pc=40", if_valid, if_pc); end
    drive(1'b0, '0, 1'b1);
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h44) begin n_fail++; $display("FAIL redir_next got v=%b pc=%h exp v=1 pc=44", if_valid, if_pc); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 32'h100, 1'b1);
    drive(1'b1, 32'h200, 1'b1);
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid got %b exp 0", if_valid); end
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin n_fail++; $display("FAIL b2b_target got v=%b pc=%h exp v=1 pc=200", if_valid, if_pc); end
    n_tests++; if (if_instr !== word_at(32'h200)) begin n_fail++; $display("FAIL b2b_instr got %h exp %h", if_instr, word_at(32'h200)); end
  endtask

  task automatic test_wrap;
    logic [W-1:0] exp_pc;
    drive(1'b1, 32'hFFFF_FFF8, 1'b1);
    drive(1'b0, '0, 1'b1);
    exp_pc = 32'hFFFF_FFF8;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1);
      n_tests++; if (if_valid !== 1'b1 || if_pc !== exp_pc) begin n_fail++; $display("FAIL wrap_pc[%0d] got v=%b pc=%h exp v=1 pc=%h", k, if_valid, if_pc, exp_pc); end
      n_tests++; if (if_instr !== word_at(exp_pc)) begin n_fail++; $display("FAIL wrap_instr[%0d] got %h exp %h", k, if_instr, word_at(exp_pc)); end
      n_tests++; if (if_pc_plus4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL wrap_plus4[%0d] got %h exp %h", k, if_pc_plus4, exp_pc + 32'd4); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_misalign;
    drive(1'b1, 32'h42, 1'b1);
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL mis_redir_valid got %b exp 0", if_valid); end
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1);
      n_tests++; if (if_misaligned !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL mis_halt[%0d] got mis=%b v=%b exp mis=1 v=0", k, if_misaligned, if_valid); end
    end
    drive(1'b1, 32'h80, 1'b1);
    drive(1'b0, '0, 1'b1);
    n_tests++; if (if_misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_clear got %b exp 0", if_misaligned); end
    drive(1'b0, '0, 1'b1);
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h80) begin n_fail++; $display("FAIL mis_resume got v=%b pc=%h exp v=1 pc=80", if_valid, if_pc); end
`else
    drive(1'b0, '0, 1'b1);
    n_tests++; if (if_misaligned !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL mis_gap got mis=%b v=%b exp mis=0 v=0", if_misaligned, if_valid); end
    drive(1'b0, '0, 1'b1);
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin n_fail++; $display("FAIL mis_forced got v=%b pc=%h exp v=1 pc=40", if_valid, if_pc); end
    n_tests++; if (if_instr !== word_at(32'h40)) begin n_fail++; $display("FAIL mis_instr got %h exp %h", if_instr, word_at(32'h40)); end
`endif
  endtask

  // Scoreboard: decode must see consecutive PCs, restarting at each redirect target, with stable heads while stalled.
  task automatic test_random;
    logic [W-1:0] exp_next, held_pc, rpc;
    logic         rv, rdy, stalled;
    int           delivered;
    delivered = 0;
    stalled   = 1'b0;
    held_pc   = '0;
    drive(1'b1, 32'h300, 1'b0);
    exp_next = 32'h300;
    for (int c = 0; c < 600; c++) begin
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 3) * 4))
                                        : ($urandom & 32'hFFFF_FFFC);
      rdy = ($urandom_range(0, 9) < 7);
      drive(rv, rpc, rdy);
      if (rv) begin
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redir_valid[%0d] got %b exp 0", c, if_valid); end
        exp_next = rpc;
        stalled  = 1'b0;
      end else begin
        if (stalled) begin
          n_tests++; if (if_valid !== 1'b1 || if_pc !== held_pc) begin n_fail++; $display("FAIL rnd_hold[%0d] got v=%b pc=%h exp v=1 pc=%h", c, if_valid, if_pc, held_pc); end
        end
        if (if_valid === 1'b1) begin
          n_tests++; if (if_pc !== exp_next || if_instr !== word_at(exp_next) || if_pc_plus4 !== exp_next + 32'd4) begin
            n_fail++; $display("FAIL rnd_head[%0d] got pc=%h instr=%h p4=%h exp pc=%h instr=%h", c, if_pc, if_instr, if_pc_plus4, exp_next, word_at(exp_next));
          end
          if (rdy) begin
            exp_next = exp_next + 32'd4;
            delivered++;
          end
        end
        stalled = (if_valid === 1'b1) && !rdy;
        held_pc = if_pc;
      end
    end
    n_tests++; if (delivered < 150) begin n_fail++; $display("FAIL rnd_throughput got %0d exp >=150", delivered); end
  endtask

  task automatic test_reset_midstream;
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    if_ready       = 1'b1;
    #1;
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b exp 0", if_valid); end
    @(negedge clk);
    #1;
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_addr got %h exp 0", imem_addr); end
    @(negedge clk);
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    #1;
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release_valid got %b exp 0", if_valid); end
    drive(1'b0, '0, 1'b1);
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_fail++; $display("FAIL mid_first got v=%b pc=%h exp v=1 pc=0", if_valid, if_pc); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_back_to_back;
    test_wrap;
    test_misalign;
    test_random;
    test_reset_midstream;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
